microsequencer: RTL and testbench

MICROSEQUENCER -- requirements
Module: microsequencer

---
 rtl/microsequencer.sv | 163 ++++++++++++++++
 tb/tb_microsequencer.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/microsequencer.sv
// Microsequencer for a small accumulator machine: walks each instruction
// through its fetch and execute steps and decodes the datapath strobes
// from the registered step.
module microsequencer #(
  parameter int OPCODE_WIDTH  = 4,
  parameter bit ILLEGAL_HALTS = 1'b0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [OPCODE_WIDTH-1:0] opcode,
  input  logic                    zero,
  input  logic                    run,
  output logic                    c_co,
  output logic                    c_mi,
  output logic                    c_ro,
  output logic                    c_ii,
  output logic                    c_ci,
  output logic                    c_j,
  output logic                    c_zi,
  output logic                    c_zo,
  output logic                    c_ai,
  output logic                    c_ao,
  output logic                    c_bi,
  output logic                    c_eo,
  output logic                    c_oi,
  output logic                    halt,
  output logic [3:0]              state,
  output logic [3:0]              cycle,
  output logic                    instr_done
);

  typedef enum logic [3:0] {
    FETCH_PC   = 4'h0,
    FETCH_INST = 4'h1,
    FETCH_ARG  = 4'h2,
    LOAD_Z     = 4'h3,
    RAM_A      = 4'h4,
    RAM_B      = 4'h5,
    ALU        = 4'h6,
    OUT_A      = 4'h7,
    JUMP       = 4'h8,
    SKIP       = 4'h9,
    HALT       = 4'hF
  } state_t;

  typedef enum logic [2:0] {
    OP_NOP, OP_LDA, OP_ADD, OP_OUT, OP_JMP, OP_JZ, OP_HLT
  } op_t;

  // Undefined opcodes fold into NOP or HLT depending on ILLEGAL_HALTS.
  function automatic op_t decode(input logic [OPCODE_WIDTH-1:0] code);
    case (code)
      OPCODE_WIDTH'(0):  decode = OP_NOP;
      OPCODE_WIDTH'(1):  decode = OP_LDA;
      OPCODE_WIDTH'(2):  decode = OP_ADD;
      OPCODE_WIDTH'(3):  decode = OP_OUT;
      OPCODE_WIDTH'(4):  decode = OP_JMP;
      OPCODE_WIDTH'(5):  decode = OP_JZ;
      OPCODE_WIDTH'(15): decode = OP_HLT;
      default:           decode = ILLEGAL_HALTS ? OP_HLT : OP_NOP;
    endcase
  endfunction

  state_t                  state_q, state_d;
  logic [3:0]              cycle_q, cycle_d;
  logic [OPCODE_WIDTH-1:0] op_q;
  logic                    final_step;
  logic                    restart;
  logic                    active;
  op_t                     cur_op;
  op_t                     fetch_op;

  // Strobes are suppressed while frozen or while reset is held.
  assign active   = run & reset;
  // The opcode is only meaningful from the register after FETCH_INST; in
  // FETCH_INST itself it is taken straight from the instruction register.
  assign cur_op   = decode(op_q);
  assign fetch_op = decode(opcode);

  // State, step counter and latched opcode; all frozen while run is low.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= FETCH_PC;
      cycle_q <= 4'd0;
      op_q    <= '0;
    end else if (run) begin
      state_q <= state_d;
      cycle_q <= cycle_d;
      if (state_q == FETCH_INST) op_q <= opcode;
    end
  end

  // Next-step selection; final_step marks the last step of an instruction.
  // NOTE: every output of this block is defaulted first so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d    = FETCH_PC;
    final_step = 1'b0;
    restart    = 1'b0;
    case (state_q)
      FETCH_PC: begin
        if (cycle_q == 4'd0) begin
          state_d = FETCH_INST;
        end else begin
          case (cur_op)
            OP_LDA, OP_ADD: state_d = FETCH_ARG;
            OP_JMP:         state_d = JUMP;
            OP_JZ:          state_d = zero ? JUMP : SKIP;
            default:        restart = 1'b1;
          endcase
        end
      end
      FETCH_INST: begin
        case (fetch_op)
          OP_NOP:  final_step = 1'b1;
          OP_OUT:  state_d = OUT_A;
          OP_HLT:  state_d = HALT;
          default: state_d = FETCH_PC;   // second fetch for the argument
        endcase
      end
      FETCH_ARG: state_d = LOAD_Z;
      LOAD_Z:    state_d = (cur_op == OP_ADD) ? RAM_B : RAM_A;
      RAM_B:     state_d = ALU;
      RAM_A, ALU, OUT_A, JUMP, SKIP: final_step = 1'b1;
      HALT:      state_d = HALT;
      default:   restart = 1'b1;         // unused codes recover to fetch
    endcase

    if (final_step || restart)  cycle_d = 4'd0;
    else if (state_q == HALT)   cycle_d = cycle_q;
    else                        cycle_d = cycle_q + 4'd1;
  end

  // Moore strobe decode from the registered step.
  always_comb begin
    c_co = 1'b0; c_mi = 1'b0; c_ro = 1'b0; c_ii = 1'b0; c_ci = 1'b0;
    c_j  = 1'b0; c_zi = 1'b0; c_zo = 1'b0; c_ai = 1'b0; c_ao = 1'b0;
    c_bi = 1'b0; c_eo = 1'b0; c_oi = 1'b0;
    if (active) begin
      case (state_q)
        FETCH_PC:   begin c_co = 1'b1; c_mi = 1'b1; end
        FETCH_INST: begin c_ro = 1'b1; c_ii = 1'b1; c_ci = 1'b1; end
        FETCH_ARG:  begin c_ro = 1'b1; c_zi = 1'b1; c_ci = 1'b1; end
        LOAD_Z:     begin c_zo = 1'b1; c_mi = 1'b1; end
        RAM_A:      begin c_ro = 1'b1; c_ai = 1'b1; end
        RAM_B:      begin c_ro = 1'b1; c_bi = 1'b1; end
        ALU:        begin c_eo = 1'b1; c_ai = 1'b1; end
        OUT_A:      begin c_ao = 1'b1; c_oi = 1'b1; end
        JUMP:       begin c_ro = 1'b1; c_j  = 1'b1; c_ci = 1'b1; end
        SKIP:       c_ci = 1'b1;
        default:    ;
      endcase
    end
  end

  assign instr_done = active & final_step;
  assign halt       = (state_q == HALT);
  assign state      = state_q;
  assign cycle      = cycle_q;

endmodule

// File: tb/tb_microsequencer.sv
// Directed bench for microsequencer: one instance with undefined opcodes
// as NOP, a second with undefined opcodes halting.
module tb_microsequencer;

  logic       clk;
  logic       reset;
  logic [3:0] opcode;
  logic       zero;
  logic       run;

  logic c_co, c_mi, c_ro, c_ii, c_ci, c_j, c_zi, c_zo, c_ai, c_ao, c_bi, c_eo, c_oi;
  logic halt, instr_done;
  logic [3:0] state, cycle;

  logic [12:0] h_strb;
  logic        h_halt, h_done;
  logic [3:0]  h_state, h_cycle;

  int n_cmp = 0;
  int n_bad = 0;

  microsequencer #(.OPCODE_WIDTH(4), .ILLEGAL_HALTS(1'b0)) u_nop (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .run(run),
    .c_co(c_co), .c_mi(c_mi), .c_ro(c_ro), .c_ii(c_ii), .c_ci(c_ci),
    .c_j(c_j), .c_zi(c_zi), .c_zo(c_zo), .c_ai(c_ai), .c_ao(c_ao),
    .c_bi(c_bi), .c_eo(c_eo), .c_oi(c_oi),
    .halt(halt), .state(state), .cycle(cycle), .instr_done(instr_done)
  );

  microsequencer #(.OPCODE_WIDTH(4), .ILLEGAL_HALTS(1'b1)) u_hlt (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .run(run),
    .c_co(h_strb[0]), .c_mi(h_strb[1]), .c_ro(h_strb[2]), .c_ii(h_strb[3]),
    .c_ci(h_strb[4]), .c_j(h_strb[5]), .c_zi(h_strb[6]), .c_zo(h_strb[7]),
    .c_ai(h_strb[8]), .c_ao(h_strb[9]), .c_bi(h_strb[10]), .c_eo(h_strb[11]),
    .c_oi(h_strb[12]),
    .halt(h_halt), .state(h_state), .cycle(h_cycle), .instr_done(h_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse reset away from any edge and present a new opcode.
  task automatic restart(input logic [3:0] op);
    reset  = 1'b0;
    opcode = op;
    #1;
    reset  = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    #2;
    n_cmp++; if (state !== 4'h0) begin n_bad++; $display("FAIL rst_state: got %0h want 0", state); end
    n_cmp++; if (cycle !== 4'h0) begin n_bad++; $display("FAIL rst_cycle: got %0h want 0", cycle); end
    n_cmp++; if ({c_co, c_mi, halt, instr_done} !== 4'b0000) begin n_bad++; $display("FAIL rst_outputs: got %b want 0000", {c_co, c_mi, halt, instr_done}); end
    tick();
    n_cmp++; if (state !== 4'h0 || cycle !== 4'h0) begin n_bad++; $display("FAIL rst_held: got %0h/%0h want 0/0", state, cycle); end
    reset = 1'b1;
    #1;
    n_cmp++; if ({c_co, c_mi, c_ro} !== 3'b110) begin n_bad++; $display("FAIL rst_release_strobes: got %b want 110", {c_co, c_mi, c_ro}); end
  endtask

  task automatic test_nop();
    restart(4'h0);
    for (int i = 0; i < 6; i++) begin
      n_cmp++; if (state !== 4'(i % 2)) begin n_bad++; $display("FAIL nop_state[%0d]: got %0h want %0h", i, state, i % 2); end
      n_cmp++; if (cycle !== 4'(i % 2)) begin n_bad++; $display("FAIL nop_cycle[%0d]: got %0h want %0h", i, cycle, i % 2); end
      n_cmp++; if (instr_done !== 1'(i % 2)) begin n_bad++; $display("FAIL nop_done[%0d]: got %b want %0d", i, instr_done, i % 2); end
      tick();
    end
  endtask

  task automatic test_lda();
    logic [3:0] es [7];
    logic [3:0] ec [7];
    logic       eci [7];
    logic       eai [7];
    es  = '{4'h0, 4'h1, 4'h0, 4'h2, 4'h3, 4'h4, 4'h0};
    ec  = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd0};
    eci = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    eai = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    restart(4'h1);
    for (int i = 0; i < 7; i++) begin
      // Opcode changes after the fetch must not disturb the instruction.
      if (i == 2) opcode = 4'h0;
      n_cmp++; if (state !== es[i]) begin n_bad++; $display("FAIL lda_state[%0d]: got %0h want %0h", i, state, es[i]); end
      n_cmp++; if (cycle !== ec[i]) begin n_bad++; $display("FAIL lda_cycle[%0d]: got %0h want %0h", i, cycle, ec[i]); end
      n_cmp++; if (c_ci !== eci[i]) begin n_bad++; $display("FAIL lda_ci[%0d]: got %b want %b", i, c_ci, eci[i]); end
      n_cmp++; if (c_ai !== eai[i]) begin n_bad++; $display("FAIL lda_ai[%0d]: got %b want %b", i, c_ai, eai[i]); end
      n_cmp++; if (instr_done !== eai[i]) begin n_bad++; $display("FAIL lda_done[%0d]: got %b want %b", i, instr_done, eai[i]); end
      if (i < 6) tick();
    end
  endtask

  task automatic test_out();
    restart(4'h3);
    tick(); tick();
    n_cmp++; if (state !== 4'h7) begin n_bad++; $display("FAIL out_state: got %0h want 7", state); end
    n_cmp++; if ({c_ao, c_oi, instr_done, c_ro} !== 4'b1110) begin n_bad++; $display("FAIL out_strobes: got %b want 1110", {c_ao, c_oi, instr_done, c_ro}); end
    tick();
    n_cmp++; if (state !== 4'h0 || cycle !== 4'h0) begin n_bad++; $display("FAIL out_wrap: got %0h/%0h want 0/0", state, cycle); end
  endtask

  task automatic test_jumps();
    // JMP
    restart(4'h4);
    tick(); tick(); tick();
    n_cmp++; if (state !== 4'h8 || cycle !== 4'd3) begin n_bad++; $display("FAIL jmp_state: got %0h/%0h want 8/3", state, cycle); end
    n_cmp++; if ({c_ro, c_j, c_ci, instr_done} !== 4'b1111) begin n_bad++; $display("FAIL jmp_strobes: got %b want 1111", {c_ro, c_j, c_ci, instr_done}); end
    // JZ taken
    zero = 1'b1;
    restart(4'h5);
    tick(); tick(); tick();
    n_cmp++; if (state !== 4'h8) begin n_bad++; $display("FAIL jz1_state: got %0h want 8", state); end
    n_cmp++; if ({c_ro, c_j, c_ci} !== 3'b111) begin n_bad++; $display("FAIL jz1_strobes: got %b want 111", {c_ro, c_j, c_ci}); end
    tick();
    n_cmp++; if (state !== 4'h0 || cycle !== 4'h0) begin n_bad++; $display("FAIL jz1_wrap: got %0h/%0h want 0/0", state, cycle); end
    // JZ not taken; zero drops only during the second FETCH_PC
    tick(); tick();
    zero = 1'b0;
    tick();
    n_cmp++; if (state !== 4'h9 || cycle !== 4'd3) begin n_bad++; $display("FAIL jz0_state: got %0h/%0h want 9/3", state, cycle); end
    n_cmp++; if ({c_ro, c_j, c_ci, instr_done} !== 4'b0011) begin n_bad++; $display("FAIL jz0_strobes: got %b want 0011", {c_ro, c_j, c_ci, instr_done}); end
  endtask

  task automatic test_run_freeze();
    restart(4'h2);
    tick(); tick(); tick(); tick();
    n_cmp++; if (state !== 4'h3 || c_zo !== 1'b1) begin n_bad++; $display("FAIL frz_pre: got %0h/%b want 3/1", state, c_zo); end
    run = 1'b0;
    #1;
    n_cmp++; if ({c_zo, c_mi} !== 2'b00) begin n_bad++; $display("FAIL frz_strobes_now: got %b want 00", {c_zo, c_mi}); end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if (state !== 4'h3 || cycle !== 4'd4) begin n_bad++; $display("FAIL frz_hold[%0d]: got %0h/%0h want 3/4", i, state, cycle); end
      n_cmp++; if ({c_zo, c_mi, instr_done} !== 3'b000) begin n_bad++; $display("FAIL frz_quiet[%0d]: got %b want 000", i, {c_zo, c_mi, instr_done}); end
    end
    run = 1'b1;
    #1;
    n_cmp++; if ({c_zo, c_mi} !== 2'b11) begin n_bad++; $display("FAIL frz_resume: got %b want 11", {c_zo, c_mi}); end
    tick();
    n_cmp++; if (state !== 4'h5 || {c_ro, c_bi} !== 2'b11) begin n_bad++; $display("FAIL add_ramb: got %0h/%b want 5/11", state, {c_ro, c_bi}); end
    tick();
    n_cmp++; if (state !== 4'h6 || cycle !== 4'd6) begin n_bad++; $display("FAIL add_alu: got %0h/%0h want 6/6", state, cycle); end
    n_cmp++; if ({c_eo, c_ai, instr_done} !== 3'b111) begin n_bad++; $display("FAIL add_alu_strobes: got %b want 111", {c_eo, c_ai, instr_done}); end
    tick();
    n_cmp++; if (state !== 4'h0 || cycle !== 4'd0) begin n_bad++; $display("FAIL add_wrap: got %0h/%0h want 0/0", state, cycle); end
  endtask

  task automatic test_halt();
    restart(4'hF);
    tick(); tick();
    n_cmp++; if (state !== 4'hF || halt !== 1'b1 || instr_done !== 1'b0) begin n_bad++; $display("FAIL hlt_enter: got %0h/%b/%b want f/1/0", state, halt, instr_done); end
    for (int i = 0; i < 12; i++) begin
      run = 1'(i % 2);
      tick();
      n_cmp++; if (state !== 4'hF || halt !== 1'b1) begin n_bad++; $display("FAIL hlt_hold[%0d]: got %0h/%b want f/1", i, state, halt); end
      n_cmp++; if ({c_co, c_mi, c_ci, instr_done} !== 4'b0000) begin n_bad++; $display("FAIL hlt_quiet[%0d]: got %b want 0000", i, {c_co, c_mi, c_ci, instr_done}); end
    end
    run = 1'b1;
    reset = 1'b0;
    #1;
    n_cmp++; if (halt !== 1'b0 || state !== 4'h0 || cycle !== 4'h0) begin n_bad++; $display("FAIL hlt_reset: got %b/%0h/%0h want 0/0/0", halt, state, cycle); end
    reset = 1'b1;
    #1;
  endtask

  task automatic test_reset_mid();
    restart(4'h1);
    tick(); tick(); tick(); tick(); tick();
    n_cmp++; if (state !== 4'h4 || c_ai !== 1'b1) begin n_bad++; $display("FAIL mid_pre: got %0h/%b want 4/1", state, c_ai); end
    reset = 1'b0;
    #1;
    n_cmp++; if ({c_ro, c_ai, instr_done, c_co} !== 4'b0000) begin n_bad++; $display("FAIL mid_abort: got %b want 0000", {c_ro, c_ai, instr_done, c_co}); end
    n_cmp++; if (state !== 4'h0) begin n_bad++; $display("FAIL mid_state: got %0h want 0", state); end
    reset = 1'b1;
    #1;
    n_cmp++; if ({c_co, c_mi} !== 2'b11 || cycle !== 4'h0) begin n_bad++; $display("FAIL mid_release: got %b/%0h want 11/0", {c_co, c_mi}, cycle); end
  endtask

  task automatic test_illegal();
    restart(4'h9);
    tick();
    n_cmp++; if (state !== 4'h1 || instr_done !== 1'b1) begin n_bad++; $display("FAIL ill_nop_done: got %0h/%b want 1/1", state, instr_done); end
    n_cmp++; if (h_state !== 4'h1 || h_done !== 1'b0) begin n_bad++; $display("FAIL ill_hlt_fetch: got %0h/%b want 1/0", h_state, h_done); end
    tick();
    n_cmp++; if (state !== 4'h0 || cycle !== 4'h0 || halt !== 1'b0) begin n_bad++; $display("FAIL ill_nop_wrap: got %0h/%0h/%b want 0/0/0", state, cycle, halt); end
    n_cmp++; if (h_state !== 4'hF || h_halt !== 1'b1) begin n_bad++; $display("FAIL ill_hlt_halt: got %0h/%b want f/1", h_state, h_halt); end
    tick();
    n_cmp++; if (state !== 4'h1 || h_state !== 4'hF) begin n_bad++; $display("FAIL ill_next: got %0h/%0h want 1/f", state, h_state); end
  endtask

  initial begin
    reset  = 1'b0;
    run    = 1'b1;
    opcode = 4'h0;
    zero   = 1'b0;
    test_reset();
    test_nop();
    test_lda();
    test_out();
    test_jumps();
    test_run_freeze();
    test_halt();
    test_reset_mid();
    test_illegal();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
